// File: rtl/mca_hist_readout.sv
// Histogram readout: streams every bin with its raw count, a 7-point moving average and a local-peak flag.
// A 9-bin raw window around the current bin is refilled with one RAM read per emitted beat.
module mca_hist_readout #(
  parameter int N_BINS = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] peak_threshold,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_bin,
  output logic [DATA_W-1:0] out_raw,
  output logic [DATA_W-1:0] out_smooth,
  output logic              out_peak,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] peak_total
);
  localparam int CNT_W = ADDR_W + 1;
  localparam int SUM_W = DATA_W + 3;
  localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(N_BINS - 1);
  localparam logic [CNT_W-1:0] END_BIN  = CNT_W'(N_BINS);

  typedef enum logic [2:0] {IDLE, PRIME, STREAM, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] win_p0 [0:8];
  logic [DATA_W-1:0] ew [0:8];
  logic              pend_p0;
  logic [2:0]        prime_cnt;
  logic [CNT_W-1:0]  cur;
  logic [DATA_W-1:0] thr;
  logic [DATA_W-1:0] sm_prev, sm_cur, sm_next;
  logic              pk;
  logic              start_acc, fire, load, advance, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              vld_p1;

  function automatic logic [DATA_W-1:0] avg7(
    input logic [DATA_W-1:0] a, b, c, d, e, f, g
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d) + SUM_W'(e) + SUM_W'(f) + SUM_W'(g);
    return DATA_W'(sum / SUM_W'(7));
  endfunction

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + DATA_W'(1);
  endfunction

  // Stage p0: window (slot 8 may still be in flight from the RAM) and per-bin statistics
  always_comb begin
    for (int k = 0; k < 9; k++) ew[k] = win_p0[k];
    if (pend_p0) ew[8] = ram_rd_data;
    // ew[k] holds raw[cur-4+k]; bins near either end pass their raw count through
    sm_prev = (cur < CNT_W'(4) || cur > CNT_W'(N_BINS - 3)) ? ew[3] :
              avg7(ew[0], ew[1], ew[2], ew[3], ew[4], ew[5], ew[6]);
    sm_cur  = (cur < CNT_W'(3) || cur > CNT_W'(N_BINS - 4)) ? ew[4] :
              avg7(ew[1], ew[2], ew[3], ew[4], ew[5], ew[6], ew[7]);
    sm_next = (cur < CNT_W'(2) || cur > CNT_W'(N_BINS - 5)) ? ew[5] :
              avg7(ew[2], ew[3], ew[4], ew[5], ew[6], ew[7], ew[8]);
    pk = (cur >= CNT_W'(1)) && (cur <= CNT_W'(N_BINS - 2)) &&
         (sm_cur > sm_prev) && (sm_cur > sm_next) && (sm_cur > thr);
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    fire      = vld_p1 && out_ready;
    load      = 1'b0;
    advance   = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(prime_cnt);
        advance = 1'b1;
        if (prime_cnt == 3'd4) state_nxt = STREAM;
      end
      STREAM, FLUSH: begin
        load = (cur < END_BIN) && (!vld_p1 || out_ready);
        if (load) begin
          advance = 1'b1;
          if (state == STREAM) begin
            rd_en   = 1'b1;
            rd_addr = ADDR_W'(cur + CNT_W'(5));
            if (cur + CNT_W'(5) == LAST_BIN) state_nxt = FLUSH;
          end
        end
        if (fire && out_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (start_acc) begin
      for (int k = 0; k < 9; k++) win_p0[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < 8; k++) win_p0[k] <= ew[k+1];
      win_p0[8] <= '0;
    end else begin
      for (int k = 0; k < 9; k++) win_p0[k] <= ew[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_p0    <= 1'b0;
      prime_cnt  <= '0;
      cur        <= '0;
      thr        <= '0;
      peak_total <= '0;
    end else begin
      pend_p0 <= rd_en;
      if (start_acc) begin
        prime_cnt  <= '0;
        cur        <= '0;
        thr        <= peak_threshold;
        peak_total <= '0;
      end else begin
        if (state == PRIME) prime_cnt <= prime_cnt + 3'd1;
        if (load) cur <= cur + CNT_W'(1);
        if (fire && out_peak) peak_total <= sat_inc(peak_total);
      end
    end
  end

  // Stage p1: output beat register, held until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      out_bin    <= '0;
      out_raw    <= '0;
      out_smooth <= '0;
      out_peak   <= 1'b0;
      out_last   <= 1'b0;
    end else if (load) begin
      vld_p1     <= 1'b1;
      out_bin    <= ADDR_W'(cur);
      out_raw    <= ew[4];
      out_smooth <= sm_cur;
      out_peak   <= pk;
      out_last   <= (cur == LAST_BIN);
    end else if (fire) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign ram_rd_en   = rd_en;
  assign ram_rd_addr = rd_addr;
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_mca_hist_readout.sv
// Bench for mca_hist_readout: table of readout runs plus reset-abort and ignored-start sequences,
// every accepted beat checked against a reference histogram smoother/peak finder.
module tb_mca_hist_readout;
  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] peak_threshold = '0;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_bin;
  logic [DW-1:0] out_raw, out_smooth, peak_total;
  logic          out_peak, out_last, busy, done;

  mca_hist_readout #(.N_BINS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .peak_threshold(peak_threshold),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_raw(out_raw),
    .out_smooth(out_smooth), .out_peak(out_peak), .out_last(out_last),
    .busy(busy), .done(done), .peak_total(peak_total)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:N-1];
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Reference: smoothing and peak rules applied directly to the histogram array
  int exp_s [0:N-1];
  bit exp_p [0:N-1];
  int exp_peaks;

  function automatic void build_model(input int thr);
    for (int i = 0; i < N; i++) begin
      if (i < 3 || i > N - 4) exp_s[i] = int'(mem[i]);
      else begin
        int s;
        s = 0;
        for (int j = -3; j <= 3; j++) s += int'(mem[i + j]);
        exp_s[i] = s / 7;
      end
    end
    exp_peaks = 0;
    for (int i = 0; i < N; i++) begin
      exp_p[i] = 1'b0;
      if (i > 0 && i < N - 1)
        if (exp_s[i] > exp_s[i-1] && exp_s[i] > exp_s[i+1] && exp_s[i] > thr) exp_p[i] = 1'b1;
      if (exp_p[i]) exp_peaks++;
    end
  endfunction

  function automatic void load_pat(input int pat);
    for (int i = 0; i < N; i++) begin
      int d;
      d = (i > 500) ? i - 500 : 500 - i;
      case (pat)
        0:       mem[i] = DW'(70);
        1:       mem[i] = (d <= 10) ? DW'(7 * (10 - d)) : '0;
        2:       mem[i] = DW'(i);
        3:       mem[i] = '1;
        default: mem[i] = DW'($urandom_range(0, 200));
      endcase
    end
  endfunction

  // Beat monitor: drives out_ready, then samples just after the falling edge
  int exp_idx = 0;
  int exp_rd = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  int got_s [0:N-1];
  bit prev_stall = 1'b0;
  logic [63:0] prev_pk = '0;

  initial begin
    logic [63:0] now_pk;
    forever begin
      @(negedge clk);
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (rst) prev_stall = 1'b0;
      else begin
        now_pk = 64'({out_bin, out_raw, out_smooth, out_peak, out_last, out_valid});
        if (prev_stall) chk("hold_while_stalled", now_pk, prev_pk);
        prev_stall = out_valid && !out_ready;
        prev_pk = now_pk;
        if (out_valid && out_ready) begin
          if (exp_idx < N) begin
            got_s[exp_idx] = int'(out_smooth);
            chk("beat", 64'({out_bin, out_raw, out_smooth, out_peak, out_last}),
                64'({AW'(exp_idx), mem[exp_idx], DW'(exp_s[exp_idx]), exp_p[exp_idx], exp_idx == N - 1}));
          end else chk("extra_beat", 64'(exp_idx), 64'(N - 1));
          exp_idx++;
        end
        if (ram_rd_en) begin
          chk("rd_addr", 64'(ram_rd_addr), 64'(exp_rd));
          exp_rd++;
        end
        if (done) begin
          done_cnt++;
          chk("busy_low_on_done", 64'(busy), 64'(0));
        end
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctrl"}, 64'({ram_rd_en, ram_rd_addr, out_valid, out_bin, out_peak, out_last, busy, done}), 64'(0));
    chk({nm, "_data"}, 64'({out_raw, out_smooth, peak_total}), 64'(0));
  endtask

  task automatic do_run(input int thr, input int mode, input int start_at, input int abort_at,
                        output int peaks_seen);
    int lat, cyc;
    bit pulsed;
    peaks_seen = -1;
    build_model(thr);
    exp_idx = 0; exp_rd = 0; done_cnt = 0; rdy_mode = mode; pulsed = 1'b0;
    @(negedge clk);
    peak_threshold = DW'(thr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    peak_threshold = DW'($urandom);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("peak_total_cleared", 64'(peak_total), 64'(0));
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_within_8", 64'(lat <= 8), 64'(1));
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (start_at >= 0 && !pulsed && exp_idx >= start_at) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else start = 1'b0;
      if (abort_at >= 0 && exp_idx >= abort_at) begin
        #3 rst = 1'b1;
        #1 chk_all_zero("abort");
        repeat (2) begin
          @(negedge clk);
          chk("no_read_in_reset", 64'(ram_rd_en), 64'(0));
        end
        rst = 1'b0;
        return;
      end
    end
    start = 1'b0;
    if (cyc >= 20000) chk("done_timeout", 64'(0), 64'(1));
    repeat (4) @(negedge clk);
    chk("beat_count", 64'(exp_idx), 64'(N));
    chk("read_count", 64'(exp_rd), 64'(N));
    chk("done_once", 64'(done_cnt), 64'(1));
    chk("busy_idle", 64'(busy), 64'(0));
    chk("peak_total_model", 64'(peak_total), 64'(exp_peaks));
    peaks_seen = int'(peak_total);
  endtask

  typedef struct {
    int pat; int thr; int mode; int exp_peaks; int probe; int probe_s;
  } vec_t;
  vec_t vec [10];

  initial begin
    int pk;
    vec[0] = '{0, 0,  0, 0, 500, 70};
    vec[1] = '{1, 50, 0, 1, 500, 58};
    vec[2] = '{1, 50, 1, 1, 499, 57};
    vec[3] = '{1, 58, 0, 0, 500, 58};
    vec[4] = '{2, 0,  0, 0, 600, 600};
    vec[5] = '{2, 0,  1, 0, 2,   2};
    vec[6] = '{2, 0,  0, 0, 1021, 1021};
    vec[7] = '{2, 0,  1, 0, 3,   3};
    vec[8] = '{3, 0,  1, 0, 10,  65535};
    vec[9] = '{4, int'($urandom_range(20, 120)), 1, -1, -1, 0};

    load_pat(0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    chk_all_zero("reset");
    @(negedge clk);
    chk("no_read_in_reset", 64'(ram_rd_en), 64'(0));
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("after_reset");

    for (int v = 0; v < 10; v++) begin
      load_pat(vec[v].pat);
      do_run(vec[v].thr, vec[v].mode, -1, -1, pk);
      if (vec[v].exp_peaks >= 0) chk("peaks_table", 64'(pk), 64'(vec[v].exp_peaks));
      if (vec[v].probe >= 0) chk("probe_smooth", 64'(got_s[vec[v].probe]), 64'(vec[v].probe_s));
    end

    load_pat(2);
    do_run(0, 0, 100, -1, pk);
    do_run(0, 1, 100, -1, pk);

    load_pat(1);
    do_run(50, 0, -1, 300, pk);
    chk_all_zero("after_abort");
    do_run(50, 0, -1, -1, pk);
    chk("peaks_after_abort", 64'(pk), 64'(1));
    repeat (5) @(negedge clk);
    chk("peak_total_holds", 64'(peak_total), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d compared, want run to finish", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
